// File: rtl/cnt_arb.sv
// cnt_arb: round-robin scheduler sharing one WIDTH-bit up-counter (delay
// timer) between NREQ requesters. A granted requester has its delay latched,
// the counter runs from 0 up to that delay while en is high, and a single
// cycle done pulse is returned to the owner.
//
// Optional feature: define CNTARB_ABORT_EN to let an owner cancel its job by
// dropping req while the counter is running (no done pulse in that case).
// With the macro undefined, a granted job always runs to completion.
//
// Handshake: req[i] is a level. A requester raises req[i] and keeps it high
// until it sees done[i]; gnt[i] is high from the cycle after arbitration up
// to the completion cycle. done[i] is high for exactly one cycle. Requests
// are only arbitrated in IDLE, so a held request is never lost.
//
// The FSM state is exported on dbg_state for observation.

module cnt_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   dly,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [WIDTH-1:0]        cnt,
    output logic [1:0]              dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  dly_q, dly_d;
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;

    // Per-requester delay slices, unpacked for simple indexing by owner.
    logic [WIDTH-1:0]  dly_arr [NREQ];

    // Round-robin selection results.
    logic              sel_valid;
    logic [IW-1:0]     sel_idx;
    int                cand;

    // Pointer value that follows the current owner (wraps at NREQ).
    logic [IW-1:0]     owner_inc;

    genvar g;
    generate
        for (g = 0; g < NREQ; g++) begin : g_dly_unpack
            assign dly_arr[g] = dly[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign owner_inc = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Pick the first asserted request at or after ptr, wrapping around.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
    end

    // Next-state and register updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = done_q;

        unique case (state_q)
            S_IDLE: begin
                if (sel_valid) begin
                    state_d          = S_RUN;
                    owner_d          = sel_idx;
                    dly_d            = dly_arr[sel_idx];
                    cnt_d            = '0;
                    gnt_d            = '0;
                    gnt_d[sel_idx]   = 1'b1;
                end
            end

            S_RUN: begin
`ifdef CNTARB_ABORT_EN
                // Owner withdrew its request: cancel silently, move on.
                if (!req[owner_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = owner_inc;
                end else
`endif
                if (en) begin
                    if (cnt_q == dly_q) begin
                        state_d         = S_DONE;
                        gnt_d           = '0;
                        done_d          = '0;
                        done_d[owner_q] = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                done_d  = '0;
                ptr_d   = owner_inc;
                cnt_d   = '0;
            end

            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                done_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            dly_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign cnt       = cnt_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cnt_arb.sv
// Directed testbench for cnt_arb (NREQ=4, WIDTH=4). Inputs are driven 1ns
// after a rising edge and outputs are checked at that same point, so each
// tick() observes the registers right after one clock edge.

module tb_cnt_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] dly;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      cnt;
    logic [1:0]            dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    cnt_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .dly       (dly),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cnt       (cnt),
        .dbg_state (dbg_state)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        en  = 1'b1;
        dly = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    // Reset values, asynchronous clear mid-job, first grant after release
    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        en  = 1'b1;
        dly = '0;
        tick();
        tick();
        n_cmp++;
        if ({gnt, done, cnt, busy, dbg_state} !== '0) begin
            n_err++;
            $display("FAIL reset_init got gnt=%b done=%b cnt=%0d busy=%b st=%0d exp all zero",
                     gnt, done, cnt, busy, dbg_state);
        end
        rst = 1'b1;
        tick();
        // Start a long job on requester 1 and reset it at cnt=5.
        dly[1*WIDTH +: WIDTH] = 4'd9;
        req = 4'b0010;
        tick();
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (cnt !== 4'd5 || gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_prerun got cnt=%0d gnt=%b exp cnt=5 gnt=0010", cnt, gnt);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || cnt !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async got gnt=%b done=%b cnt=%0d busy=%b exp 0000 0000 0 0",
                     gnt, done, cnt, busy);
        end
        req = 4'b0011;
        dly = '0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_first_gnt got %b exp 0001", gnt);
        end
        tick();
        n_cmp++;
        if (done !== 4'b0001) begin
            n_err++;
            $display("FAIL reset_first_done got %b exp 0001", done);
        end
        req = '0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_back_idle got busy=%b done=%b exp 0 0000", busy, done);
        end
    endtask

    // Single job on requester 2 with D=3
    task automatic test_single();
        dly[2*WIDTH +: WIDTH] = 4'd3;
        en  = 1'b1;
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || cnt !== 4'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_gnt got gnt=%b cnt=%0d busy=%b exp 0100 0 1", gnt, cnt, busy);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (cnt !== 4'(i) || done !== 4'b0000 || gnt !== 4'b0100) begin
                n_err++;
                $display("FAIL single_step%0d got cnt=%0d done=%b gnt=%b exp cnt=%0d 0000 0100",
                         i, cnt, done, gnt, i);
            end
        end
        tick();
        n_cmp++;
        if (done !== 4'b0100 || gnt !== 4'b0000 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_done got done=%b gnt=%b busy=%b exp 0100 0000 1", done, gnt, busy);
        end
        req = '0;
        tick();
        n_cmp++;
        if (done !== 4'b0000 || busy !== 1'b0 || cnt !== 4'd0) begin
            n_err++;
            $display("FAIL single_end got done=%b busy=%b cnt=%0d exp 0000 0 0", done, busy, cnt);
        end
    endtask

    // All four requesters held with D=0: grants rotate 0,1,2,3,0
    task automatic test_round_robin();
        logic [NREQ-1:0] exp_oh;
        do_reset();
        dly = '0;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_oh = 4'b0001 << (j % NREQ);
            tick();
            n_cmp++;
            if (gnt !== exp_oh || done !== 4'b0000) begin
                n_err++;
                $display("FAIL rr_gnt%0d got gnt=%b done=%b exp %b 0000", j, gnt, done, exp_oh);
            end
            tick();
            n_cmp++;
            if (done !== exp_oh || gnt !== 4'b0000) begin
                n_err++;
                $display("FAIL rr_done%0d got done=%b gnt=%b exp %b 0000", j, done, gnt, exp_oh);
            end
            if (j == 4) req = '0;
            tick();
            n_cmp++;
            if (busy !== 1'b0 || done !== 4'b0000) begin
                n_err++;
                $display("FAIL rr_idle%0d got busy=%b done=%b exp 0 0000", j, busy, done);
            end
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL rr_quiet got busy=%b gnt=%b exp 0 0000", busy, gnt);
        end
    endtask

    // en low for 3 cycles at cnt=1 delays done by 3 cycles (4 -> 7 ticks)
    task automatic test_enable_stall();
        int ticks;
        dly[1*WIDTH +: WIDTH] = 4'd2;
        en  = 1'b1;
        req = 4'b0010;
        tick();
        tick();
        ticks = 2;
        n_cmp++;
        if (cnt !== 4'd1 || gnt !== 4'b0010) begin
            n_err++;
            $display("FAIL stall_pre got cnt=%0d gnt=%b exp 1 0010", cnt, gnt);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ticks++;
            n_cmp++;
            if (cnt !== 4'd1 || done !== 4'b0000 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold%0d got cnt=%0d done=%b busy=%b exp 1 0000 1",
                         i, cnt, done, busy);
            end
        end
        en = 1'b1;
        while (done === 4'b0000 && ticks < 20) begin
            tick();
            ticks++;
        end
        n_cmp++;
        if (ticks !== 7 || done !== 4'b0010) begin
            n_err++;
            $display("FAIL stall_latency got ticks=%0d done=%b exp 7 0010", ticks, done);
        end
        req = '0;
        tick();
    endtask

    // D=15 runs to the top without wrapping; dly change mid-run is ignored
    task automatic test_boundary();
        dly[0*WIDTH +: WIDTH] = 4'd15;
        en  = 1'b1;
        req = 4'b0001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001 || cnt !== 4'd0) begin
            n_err++;
            $display("FAIL bnd_gnt got gnt=%b cnt=%0d exp 0001 0", gnt, cnt);
        end
        dly[0*WIDTH +: WIDTH] = 4'd1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++;
            if (cnt !== 4'(i) || done !== 4'b0000) begin
                n_err++;
                $display("FAIL bnd_step%0d got cnt=%0d done=%b exp %0d 0000", i, cnt, done, i);
            end
        end
        tick();
        n_cmp++;
        if (done !== 4'b0001 || cnt !== 4'd15) begin
            n_err++;
            $display("FAIL bnd_done got done=%b cnt=%0d exp 0001 15", done, cnt);
        end
        req = '0;
        tick();
        n_cmp++;
        if (done !== 4'b0000 || cnt !== 4'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bnd_end got done=%b cnt=%0d busy=%b exp 0000 0 0", done, cnt, busy);
        end
    endtask

    // Owner 3 drops req at cnt=2 while requester 0 waits
    task automatic test_abort();
        dly = '0;
        dly[3*WIDTH +: WIDTH] = 4'd6;
        en  = 1'b1;
        req = 4'b1000;
        tick();
        tick();
        tick();
        n_cmp++;
        if (cnt !== 4'd2 || gnt !== 4'b1000) begin
            n_err++;
            $display("FAIL abort_pre got cnt=%0d gnt=%b exp 2 1000", cnt, gnt);
        end
        req = 4'b0001;
`ifdef CNTARB_ABORT_EN
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || cnt !== 4'd0) begin
            n_err++;
            $display("FAIL abort_cancel got gnt=%b done=%b busy=%b cnt=%0d exp 0000 0000 0 0",
                     gnt, done, busy, cnt);
        end
`else
        for (int i = 3; i <= 6; i++) begin
            tick();
            n_cmp++;
            if (cnt !== 4'(i) || gnt !== 4'b1000 || done !== 4'b0000) begin
                n_err++;
                $display("FAIL abort_run%0d got cnt=%0d gnt=%b done=%b exp %0d 1000 0000",
                         i, cnt, gnt, done, i);
            end
        end
        tick();
        n_cmp++;
        if (done !== 4'b1000 || gnt !== 4'b0000) begin
            n_err++;
            $display("FAIL abort_done got done=%b gnt=%b exp 1000 0000", done, gnt);
        end
        tick();
`endif
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL abort_next_gnt got %b exp 0001", gnt);
        end
        tick();
        n_cmp++;
        if (done !== 4'b0001) begin
            n_err++;
            $display("FAIL abort_next_done got %b exp 0001", done);
        end
        req = '0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        req = '0;
        dly = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_enable_stall();
        test_boundary();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
